// File: rtl/eeprom_writer.sv
// Boot-region save engine: copies the top 2^W bytes of RAM into the EEPROM.
// Each byte is written, the EEPROM write cycle is waited out, then the byte is read back and verified.
module eeprom_writer #(
  parameter int unsigned EEPROM_ADDRESS_BUS_WIDTH = 13,
  parameter int unsigned WRITE_WAIT_CYCLES        = 10000,
  parameter int unsigned WAIT_COUNTER_WIDTH       = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  data_in,
  output logic [15:0] address,
  output logic        ram_cs_n,
  output logic        ram_oe_n,
  output logic        eeprom_cs_n,
  output logic        eeprom_oe_n,
  output logic        eeprom_we_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned OW = EEPROM_ADDRESS_BUS_WIDTH;
  localparam int unsigned CW = WAIT_COUNTER_WIDTH;
  localparam logic [15:0]   ADDR_HIGH   = 16'hFFFF << OW;
  localparam logic [OW-1:0] OFFSET_LAST = '1;
  localparam logic [CW-1:0] WAIT_LOAD   = CW'(WRITE_WAIT_CYCLES - 1);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_READ_RAM    = 4'd1;
  localparam logic [3:0] S_LATCH       = 4'd2;
  localparam logic [3:0] S_WE_LOW      = 4'd3;
  localparam logic [3:0] S_WE_HIGH     = 4'd4;
  localparam logic [3:0] S_WAIT        = 4'd5;
  localparam logic [3:0] S_VERIFY_READ = 4'd6;
  localparam logic [3:0] S_COMPARE     = 4'd7;
  localparam logic [3:0] S_NEXT        = 4'd8;
  localparam logic [3:0] S_DONE        = 4'd9;
  localparam logic [3:0] S_ERROR       = 4'd10;

  logic [3:0]    state, state_next;
  logic [OW-1:0] offset, offset_next;
  logic [CW-1:0] wait_count, wait_count_next;
  logic [7:0]    byte_reg, byte_next;
  logic [15:0]   address_next;
  logic          ram_cs_n_next, ram_oe_n_next;
  logic          eeprom_cs_n_next, eeprom_oe_n_next, eeprom_we_n_next;
  logic          busy_next, done_next, error_next;

  // Next state, datapath updates, and outputs decoded from the next state so they register with it
  always_comb begin
    state_next      = state;
    offset_next     = offset;
    wait_count_next = wait_count;
    byte_next       = byte_reg;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next  = S_READ_RAM;
          offset_next = '0;
        end
      end
      S_READ_RAM: state_next = S_LATCH;
      S_LATCH: begin
        byte_next  = data_in;
        state_next = S_WE_LOW;
      end
      S_WE_LOW: state_next = S_WE_HIGH;
      S_WE_HIGH: begin
        wait_count_next = WAIT_LOAD;
        state_next      = S_WAIT;
      end
      S_WAIT: begin
        if (wait_count == '0) state_next = S_VERIFY_READ;
        else                  wait_count_next = wait_count - CW'(1);
      end
      S_VERIFY_READ: state_next = S_COMPARE;
      S_COMPARE: begin
        if (data_in != byte_reg) state_next = S_ERROR;
        else                     state_next = S_NEXT;
      end
      S_NEXT: begin
        if (offset == OFFSET_LAST) begin
          state_next = S_DONE;
        end else begin
          offset_next = offset + OW'(1);
          state_next  = S_READ_RAM;
        end
      end
      default: state_next = S_IDLE;
    endcase

    ram_cs_n_next    = 1'b1;
    ram_oe_n_next    = 1'b1;
    eeprom_cs_n_next = 1'b1;
    eeprom_oe_n_next = 1'b1;
    eeprom_we_n_next = 1'b1;
    busy_next        = 1'b1;
    done_next        = 1'b0;
    error_next       = 1'b0;
    address_next     = ADDR_HIGH | 16'(offset_next);

    case (state_next)
      S_IDLE: busy_next = 1'b0;
      S_READ_RAM, S_LATCH: begin
        ram_cs_n_next = 1'b0;
        ram_oe_n_next = 1'b0;
      end
      S_WE_LOW: begin
        ram_cs_n_next    = 1'b0;
        ram_oe_n_next    = 1'b0;
        eeprom_cs_n_next = 1'b0;
        eeprom_we_n_next = 1'b0;
      end
      S_WE_HIGH: begin
        // RAM keeps driving so the EEPROM sees stable data at the rising edge of we_n
        ram_cs_n_next    = 1'b0;
        ram_oe_n_next    = 1'b0;
        eeprom_cs_n_next = 1'b0;
      end
      S_VERIFY_READ, S_COMPARE: begin
        eeprom_cs_n_next = 1'b0;
        eeprom_oe_n_next = 1'b0;
      end
      S_DONE: begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      S_ERROR: begin
        busy_next  = 1'b0;
        error_next = 1'b1;
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      offset      <= '0;
      wait_count  <= '0;
      byte_reg    <= '0;
      address     <= ADDR_HIGH;
      ram_cs_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      eeprom_cs_n <= 1'b1;
      eeprom_oe_n <= 1'b1;
      eeprom_we_n <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      offset      <= offset_next;
      wait_count  <= wait_count_next;
      byte_reg    <= byte_next;
      address     <= address_next;
      ram_cs_n    <= ram_cs_n_next;
      ram_oe_n    <= ram_oe_n_next;
      eeprom_cs_n <= eeprom_cs_n_next;
      eeprom_oe_n <= eeprom_oe_n_next;
      eeprom_we_n <= eeprom_we_n_next;
      busy        <= busy_next;
      done        <= done_next;
      error       <= error_next;
    end
  end

endmodule
